// File: rtl/divider_unit_pkg.sv
// Shared execute-stage types: divider FSM states, opcode enum and divider constants.
package divider_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } div_states_e;

  // Execute-stage opcode; only the division group is consumed by this unit.
  typedef enum logic [49:0] {
    NOP    = 50'd0,
    ADD    = 50'd1,
    SUB    = 50'd2,
    MUL    = 50'd3,
    MULH   = 50'd4,
    MULHU  = 50'd5,
    MULHSU = 50'd6,
    DIV    = 50'd7,
    DIVU   = 50'd8,
    REM    = 50'd9,
    REMU   = 50'd10
  } iType_e;

endpackage

// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            kill_i,
  input  iType_e          instruction_operation_i,
  input  logic [XLEN-1:0] first_operand_i,
  input  logic [XLEN-1:0] second_operand_i,
  output logic            hold_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  div_states_e state, next_state;

  iType_e          op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] quot_q, divisor_q;
  logic [XLEN:0]   rem_q;
  logic [4:0]      cnt_q;
  logic            neg_q_q, neg_r_q;

  logic            in_div_op, in_signed, accept;
  logic            op_signed, op_is_rem;
  logic            zero_div, ovf, early;
  logic [XLEN-1:0] early_res, sign_sel, sign_res, a_mag, b_mag;
  logic            finish;
  logic [XLEN-1:0] fin_val;
  logic [2*XLEN:0] step_res;

  // One restoring step: shift {rem,quot} left, try subtracting the divisor, keep it if non-negative.
  // rem[32] is always 0 here but is carried so the trial is computed at full width.
  function automatic logic [2*XLEN:0] div_step(input logic [XLEN:0] rem,
                                               input logic [XLEN-1:0] quot,
                                               input logic [XLEN-1:0] dvs);
    logic [XLEN+1:0] rem_sh, trial;
    rem_sh = {rem, quot[XLEN-1]};
    trial  = rem_sh - {2'b00, dvs};
    if (!trial[XLEN+1]) div_step = {trial[XLEN:0], quot[XLEN-2:0], 1'b1};
    else                div_step = {rem_sh[XLEN:0], quot[XLEN-2:0], 1'b0};
  endfunction

  assign in_div_op = (instruction_operation_i == DIV)  || (instruction_operation_i == DIVU) ||
                     (instruction_operation_i == REM)  || (instruction_operation_i == REMU);
  assign in_signed = (instruction_operation_i == DIV)  || (instruction_operation_i == REM);
  assign accept    = (state == D_IDLE) && start_i && in_div_op && !kill_i;

  assign op_signed = (op_q == DIV) || (op_q == REM);
  assign op_is_rem = (op_q == REM) || (op_q == REMU);

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (op_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_mag = (op_signed && b_q[XLEN-1]) ? -b_q : b_q;

  assign zero_div  = (b_q == '0);
  assign ovf       = op_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign early     = EARLY_EXIT && (zero_div || ovf);
  assign early_res = zero_div ? (op_is_rem ? a_q : DIV_BY_ZERO_Q)
                              : (op_is_rem ? '0  : 32'h8000_0000);

  assign sign_sel  = op_is_rem ? rem_q[XLEN-1:0] : quot_q;
  assign sign_res  = (op_is_rem ? neg_r_q : neg_q_q) ? -sign_sel : sign_sel;

  assign step_res  = div_step(rem_q, quot_q, divisor_q);

  assign hold_o    = (state != D_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= D_IDLE;
    else       state <= next_state;
  end

  // Next-state and completion decode; a flush cancels any completion this cycle.
  always_comb begin
    next_state = state;
    finish     = 1'b0;
    fin_val    = sign_res;
    case (state)
      D_IDLE: if (accept) next_state = D_INIT;
      D_INIT: begin
        if (early) begin
          finish     = 1'b1;
          fin_val    = early_res;
          next_state = D_IDLE;
        end else begin
          next_state = D_CALC;
        end
      end
      D_CALC: if (cnt_q == 5'd0) next_state = D_SIGN;
      D_SIGN: begin
        finish     = 1'b1;
        fin_val    = sign_res;
        next_state = D_IDLE;
      end
      default: next_state = D_IDLE;
    endcase
    if (kill_i && state != D_IDLE) begin
      next_state = D_IDLE;
      finish     = 1'b0;
    end
  end

  // Datapath: operand capture, iteration registers and registered result/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= NOP;
      a_q       <= '0;
      b_q       <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
    end else begin
      done_o <= finish;
      if (finish) result_o <= fin_val;
      case (state)
        D_IDLE: if (accept) begin
          op_q    <= instruction_operation_i;
          a_q     <= first_operand_i;
          b_q     <= second_operand_i;
          neg_q_q <= in_signed && (first_operand_i[XLEN-1] ^ second_operand_i[XLEN-1]) &&
                     (second_operand_i != '0);
          neg_r_q <= in_signed && first_operand_i[XLEN-1];
        end
        D_INIT: begin
          quot_q    <= a_mag;
          divisor_q <= b_mag;
          rem_q     <= '0;
          cnt_q     <= 5'd31;
        end
        D_CALC: begin
          {rem_q, quot_q} <= step_res;
          cnt_q           <= cnt_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed vectors, expected results queued at issue.
module tb_divider_unit;
  import divider_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start_i, kill_i;
  iType_e      op_i;
  logic [31:0] a_i, b_i;
  logic        hold_o, done_o;
  logic [31:0] result_o;

  divider_unit #(.EARLY_EXIT(1'b1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start_i                 (start_i),
    .kill_i                  (kill_i),
    .instruction_operation_i (op_i),
    .first_operand_i         (a_i),
    .second_operand_i        (b_i),
    .hold_o                  (hold_o),
    .done_o                  (done_o),
    .result_o                (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sb_res[$];
  int          sb_cyc[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // Directed probe request, evaluated by the monitor in the same cycle.
  bit          p_en = 0, p_hold, p_done, p_chk_res, fin_chk = 0;
  logic [31:0] p_res;
  string       p_name;

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (done_o) begin
      n_chk++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result_o);
      end else begin
        logic [31:0] er;
        int ec;
        er = sb_res.pop_front();
        ec = sb_cyc.pop_front();
        if (result_o !== er || cyc != ec) begin
          n_fail++;
          $display("FAIL sb_result got=%h exp=%h got_cyc=%0d exp_cyc=%0d", result_o, er, cyc, ec);
        end
      end
    end
    if (p_en) begin
      n_chk++;
      if (hold_o !== p_hold || done_o !== p_done || (p_chk_res && result_o !== p_res)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d hold=%b/%b done=%b/%b result=%h/%h (got/exp)",
                 p_name, cyc, hold_o, p_hold, done_o, p_done, result_o, p_res);
      end
    end
    if (fin_chk) begin
      n_chk++;
      if (sb_res.size() != 0) begin
        n_fail++;
        $display("FAIL sb_drain pending=%0d exp=0", sb_res.size());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic probe(input bit h, input bit d, input bit cr, input logic [31:0] r, input string nm);
    p_hold = h; p_done = d; p_chk_res = cr; p_res = r; p_name = nm; p_en = 1;
    @(posedge clk); #1;
    p_en = 0;
  endtask

  // Present a one-cycle start; optionally queue the expected result and completion cycle.
  task automatic issue(input iType_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    start_i = 1; op_i = op; a_i = a; b_i = b;
    if (push) begin
      sb_res.push_back(exp);
      sb_cyc.push_back(cyc + lat);
    end
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic run(input iType_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(op, a, b, exp, lat, 1);
    step(lat);
  endtask

  initial begin
    reset = 1; start_i = 0; kill_i = 0; op_i = NOP; a_i = '0; b_i = '0;
    step(3);
    reset = 0;
    probe(0, 0, 1, 32'h0, "reset_state");

    // Unsigned with hold window t+1..t+34, done at t+35.
    issue(DIVU, 32'd100, 32'd7, 32'd14, 35, 1);
    for (int k = 1; k <= 34; k++) probe(1, 0, 0, 32'h0, "hold_busy");
    probe(0, 1, 1, 32'd14, "hold_done");
    run(REMU, 32'd100, 32'd7, 32'd2, 35);

    // Signed.
    run(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
    run(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
    run(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35);
    run(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35);

    // Early exits: divide-by-zero and signed overflow.
    run(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run(REMU, 32'd5, 32'd0, 32'd5, 2);
    run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    // Unsigned boundary values (same operands as overflow take the full path).
    run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 35);
    run(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35);
    run(DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 35);
    run(REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 35);

    // Non-division opcode is ignored.
    issue(ADD, 32'd1, 32'd1, 32'h0, 0, 0);
    probe(0, 0, 1, 32'hF, "ignore_bad_op");

    // Start while busy is ignored.
    issue(DIVU, 32'd1000, 32'd10, 32'd100, 35, 1);
    step(9);
    issue(DIVU, 32'd50, 32'd5, 32'h0, 0, 0);
    step(25);

    // Flush at t+20: idle at t+21, result unchanged, no completion.
    issue(DIVU, 32'd77, 32'd7, 32'h0, 0, 0);
    step(19);
    kill_i = 1;
    step(1);
    kill_i = 0;
    probe(0, 0, 1, 32'd100, "kill_idle");
    step(40);

    // Kill with start in idle drops the start.
    start_i = 1; kill_i = 1; op_i = DIVU; a_i = 32'd8; b_i = 32'd2;
    step(1);
    start_i = 0; kill_i = 0;
    probe(0, 0, 1, 32'd100, "kill_drops_start");
    step(40);

    // Back-to-back: new start in the done cycle.
    issue(DIVU, 32'd100, 32'd7, 32'd14, 35, 1);
    step(34);
    issue(REMU, 32'd100, 32'd7, 32'd2, 35, 1);
    probe(1, 0, 1, 32'd14, "b2b_busy");
    step(34);

    // Reset mid-calculation.
    issue(DIVU, 32'd1000, 32'd3, 32'h0, 0, 0);
    step(14);
    reset = 1;
    step(1);
    reset = 0;
    probe(0, 0, 1, 32'h0, "reset_mid");
    run(DIVU, 32'd9, 32'd3, 32'd3, 35);

    step(5);
    fin_chk = 1;
    @(negedge clk); #1;
    fin_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
